muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage, beside the ALU and its controller.
//  Accepts one M-extension op (Funct7=0000001), sequences a radix-2 shift-add multiply or restoring divide.
//  Stalls the pipeline while working, then presents the result for one cycle.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; iteration count equals DATA_WIDTH
// PORTS
//  clk       in   1           rising-edge clock (single clock domain)
//  reset     in   1           synchronous, active-high reset
//  Start     in   1           EX holds a valid M-op; sampled only in IDLE
//  Flush     in   1           kill in-flight op (branch mispredict / trap)
//  Funct3    in   3           000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  SrcA      in   DATA_WIDTH  rs1 value (multiplicand / dividend)
//  SrcB      in   DATA_WIDTH  rs2 value (multiplier / divisor)
//  Stall     out  1           freeze IF/ID/EX while an op is in progress
//  Done      out  1           one-cycle pulse: Result valid, EX may advance
//  Result    out  DATA_WIDTH  rd value; held until next accepted Start
// BEHAVIOUR
//  Reset: state=IDLE, Stall=0, Done=0, Result=0, counter=0; reset wins over Start/Flush and aborts any op.
//  States: IDLE, CALC, FIX, DONE.
//  IDLE: Start=1 latches Funct3, operands and sign flags. Normal op -> CALC, counter=DATA_WIDTH-1.
//   Div-by-zero (SrcB=0, Funct3[2]=1) -> DONE directly: DIV/DIVU=all ones, REM/REMU=SrcA.
//   Signed overflow (DIV/REM, SrcA=0x8000_0000, SrcB=all ones) -> DONE directly: DIV=0x8000_0000, REM=0.
//  CALC: one iteration per cycle on operand magnitudes (signed per op: MULH both, MULHSU rs1 only, DIV/REM both).
//   Mul: 2*DATA_WIDTH accumulator. Div: quotient + DATA_WIDTH+1-bit partial remainder.
//   counter==0 -> FIX, else counter-1.
//  FIX: apply sign fix to a 2W-bit product (negate if signs differ) or to quotient/remainder.
//   Remainder takes the dividend sign. Select low half (MUL), high half (MULH*), quotient or remainder.
//   Register Result; -> DONE.
//  DONE: Done=1 for exactly this cycle; -> IDLE. Start is not sampled in DONE.
//  Stall = (IDLE & Start & Funct7-qualified op) | CALC | FIX; combinational, so the start cycle is stalled. Stall=0 in DONE.
//  Latency: Start in cycle 0 -> Done in cycle DATA_WIDTH+2 (cycle 34 at 32 bits); special cases -> Done in cycle 1.
//  Start while not IDLE: ignored. No queueing; a new op waits until the cycle after DONE.
//  Flush in any state: -> IDLE next edge, Done suppressed, Stall=0 next cycle, Result unchanged.
//   Flush outranks Start in the same IDLE cycle, so that op is not accepted.
//  All arithmetic is modulo 2^DATA_WIDTH; no X on outputs after reset.
// TESTING
//  MUL 7 * -3: Start cycle 0 -> Stall 0..33, Done cycle 34, Result=0xFFFF_FFEB.
//  MULH 0x8000_0000*0x8000_0000 -> 0x4000_0000. MULHU 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE.
//  MULHSU -1*2 -> 0xFFFF_FFFF.
//  DIV -7/2 -> 0xFFFF_FFFD. REM -7/2 -> 0xFFFF_FFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each Done at cycle 34.
//  DIVU 5/0 -> 0xFFFF_FFFF; REM 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000. Each Done at cycle 1.
//  Flush in cycle 10 of a DIV -> IDLE, no Done, Result keeps prior value; next Start completes normally.
//  Start pulsed during CALC -> ignored. Reset in cycle 15 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage is the master; the sequencer is the slave.
interface muldiv_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  Start;
  logic                  Flush;
  logic [2:0]            Funct3;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  Stall;
  logic                  Done;
  logic [DATA_WIDTH-1:0] Result;

  modport master (
    output Start, Flush, Funct3, SrcA, SrcB,
    input  Stall, Done, Result
  );

  modport slave (
    input  Start, Flush, Funct3, SrcA, SrcB,
    output Stall, Done, Result
  );

endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, sign fix-up in a final cycle, one-cycle Done pulse.
module muldiv_sequencer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            a_neg_q, a_neg_d;
  logic            b_neg_q, b_neg_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    result_q, result_d;

  logic            a_signed_c, b_signed_c;
  logic            a_neg_c, b_neg_c;
  logic [W-1:0]    a_mag_c, b_mag_c;
  logic            div_zero_c, div_ovf_c, accept_c;
  logic [W:0]      mul_sum_c, div_trial_c;
  logic [2*W-1:0]  prod_c;
  logic [W-1:0]    quo_c, rem_c, fix_c;

  // Operand decode: which sources are signed for this op, magnitudes, fast-path cases.
  always_comb begin
    a_signed_c = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
                 (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
    b_signed_c = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b100) ||
                 (bus.Funct3 == 3'b110);
    a_neg_c    = a_signed_c && bus.SrcA[W-1];
    b_neg_c    = b_signed_c && bus.SrcB[W-1];
    a_mag_c    = a_neg_c ? W'(-bus.SrcA) : bus.SrcA;
    b_mag_c    = b_neg_c ? W'(-bus.SrcB) : bus.SrcB;
    div_zero_c = bus.Funct3[2] && (bus.SrcB == '0);
    div_ovf_c  = bus.Funct3[2] && !bus.Funct3[0] &&
                 (bus.SrcA == MIN_NEG) && (bus.SrcB == '1);
    accept_c   = (state_q == ST_IDLE) && bus.Start && !bus.Flush;
  end

  // Iteration step and final sign fix-up. acc holds {hi, lo} for multiply, {rem, quo} for divide.
  always_comb begin
    mul_sum_c   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    div_trial_c = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
    prod_c      = (a_neg_q ^ b_neg_q) ? (2*W)'(-acc_q) : acc_q;
    quo_c       = (a_neg_q ^ b_neg_q) ? W'(-acc_q[W-1:0]) : acc_q[W-1:0];
    rem_c       = a_neg_q ? W'(-acc_q[2*W-1:W]) : acc_q[2*W-1:W];
    if (op_q[2]) begin
      fix_c = op_q[1] ? rem_c : quo_c;
    end else begin
      fix_c = (op_q[1:0] == 2'b00) ? prod_c[W-1:0] : prod_c[2*W-1:W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_d    = bus.Funct3;
          a_neg_d = a_neg_c;
          b_neg_d = b_neg_c;
          if (div_zero_c) begin
            result_d = bus.Funct3[1] ? bus.SrcA : {W{1'b1}};
            state_d  = ST_DONE;
          end else if (div_ovf_c) begin
            result_d = bus.Funct3[1] ? {W{1'b0}} : MIN_NEG;
            state_d  = ST_DONE;
          end else begin
            cnt_d   = CNT_W'(W - 1);
            state_d = ST_CALC;
            if (bus.Funct3[2]) begin
              opnd_d = b_mag_c;
              acc_d  = {{W{1'b0}}, a_mag_c};
            end else begin
              opnd_d = a_mag_c;
              acc_d  = {{W{1'b0}}, b_mag_c};
            end
          end
        end
      end
      ST_CALC: begin
        if (op_q[2]) begin
          // Restoring step: keep the trial difference only when it did not go negative.
          if (div_trial_c[W]) begin
            acc_d = {acc_q[2*W-2:0], 1'b0};
          end else begin
            acc_d = {div_trial_c[W-1:0], acc_q[W-2:0], 1'b1};
          end
        end else begin
          acc_d = {mul_sum_c, acc_q[W-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIX: begin
        result_d = fix_c;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A killed op never reaches DONE and never overwrites the visible result.
    if (bus.Flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Stall covers the accepting cycle itself so EX holds the instruction from the start.
  assign bus.Stall  = accept_c || (state_q == ST_CALC) || (state_q == ST_FIX);
  assign bus.Done   = (state_q == ST_DONE) && !bus.Flush;
  assign bus.Result = result_q;

endmodule
